// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous VRAM between video fetch,
// the HPS download path and the game CPU (priority video > download > CPU).
// Video sees a fixed 2-cycle read latency; the CPU is stalled via req/ack.
// Optional grant/wait statistics are compiled in with `define VRAM_ARB_STATS_EN.
module vram_arbiter #(
    parameter int AW         = 11,
    parameter int DW         = 8,
    parameter int STARVE_LIM = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_data,
    output logic          vid_valid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          dl_active,
    input  logic          dl_wr,
    input  logic [AW-1:0] dl_addr,
    input  logic [DW-1:0] dl_data,
    output logic          dl_busy,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
`ifdef VRAM_ARB_STATS_EN
    output logic [15:0]   stat_vid_cnt,
    output logic [15:0]   stat_cpu_cnt,
    output logic [15:0]   stat_dl_cnt,
    output logic [7:0]    stat_max_wait,
`endif
    output logic          cpu_starve
);

    typedef enum logic [1:0] {C_IDLE, C_ISSUED, C_ACK, C_HOLD} cstate_t;

    localparam logic [7:0] LP_LIM = 8'(STARVE_LIM);

    cstate_t       r_cst, w_cst_nxt;
    logic [7:0]    r_wait, w_wait_nxt;
    logic          r_starve;
    logic          r_cpu_we;
    logic          r_cpu_ack;
    logic [DW-1:0] r_cpu_rdata;
    logic [1:0]    r_vld_pipe;
    logic          r_dl_busy;
    logic [AW-1:0] r_dl_addr;
    logic [DW-1:0] r_dl_data;
    logic [AW-1:0] r_ram_addr;
    logic          r_ram_we;
    logic [DW-1:0] r_ram_wdata;

    logic w_vid_gnt, w_dl_gnt, w_cpu_gnt, w_dl_load;

    // Video always wins; the buffered download write fills the next video gap;
    // the CPU only gets truly idle cycles and never while a download runs.
    assign w_vid_gnt = vid_req;
    assign w_dl_gnt  = r_dl_busy & ~vid_req;
    assign w_cpu_gnt = (r_cst == C_IDLE) & cpu_req & ~vid_req & ~r_dl_busy & ~dl_active;
    // A strobe while the buffer is full is a loader protocol error and is dropped.
    assign w_dl_load = dl_wr & dl_active & ~r_dl_busy;

    assign ram_addr   = r_ram_addr;
    assign ram_we     = r_ram_we;
    assign ram_wdata  = r_ram_wdata;
    assign vid_valid  = r_vld_pipe[1];
    // RAM output register supplies the data; gating keeps it 0 outside a strobe.
    assign vid_data   = r_vld_pipe[1] ? ram_rdata : '0;
    assign cpu_ack    = r_cpu_ack;
    assign cpu_rdata  = r_cpu_rdata;
    assign dl_busy    = r_dl_busy;
    assign cpu_starve = r_starve;

    // CPU FSM next state and wait-counter update
    always_comb begin
        w_cst_nxt  = r_cst;
        w_wait_nxt = r_wait;
        case (r_cst)
            C_IDLE: begin
                if (w_cpu_gnt) begin
                    w_cst_nxt  = C_ISSUED;
                    w_wait_nxt = '0;
                end else if (cpu_req && r_wait != 8'hFF) begin
                    w_wait_nxt = r_wait + 8'd1;
                end
            end
            C_ISSUED: w_cst_nxt = C_ACK;
            C_ACK:    w_cst_nxt = C_HOLD;
            // Requester must drop req before another access can issue.
            C_HOLD:   if (!cpu_req) w_cst_nxt = C_IDLE;
            default:  w_cst_nxt = C_IDLE;
        endcase
    end

    // CPU FSM state, wait counter, sticky starvation flag and ack/rdata registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cst       <= C_IDLE;
            r_wait      <= '0;
            r_starve    <= 1'b0;
            r_cpu_we    <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_cpu_rdata <= '0;
        end else begin
            r_cst     <= w_cst_nxt;
            r_wait    <= w_wait_nxt;
            r_cpu_ack <= (r_cst == C_ACK);
            if (w_wait_nxt >= LP_LIM) r_starve <= 1'b1;
            if (w_cpu_gnt) r_cpu_we <= cpu_we;
            // RAM data for the issued access is on ram_rdata during C_ACK.
            if (r_cst == C_ACK && !r_cpu_we) r_cpu_rdata <= ram_rdata;
        end
    end

    // One-entry download buffer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dl_busy <= 1'b0;
            r_dl_addr <= '0;
            r_dl_data <= '0;
        end else if (w_dl_load) begin
            r_dl_busy <= 1'b1;
            r_dl_addr <= dl_addr;
            r_dl_data <= dl_data;
        end else if (w_dl_gnt) begin
            r_dl_busy <= 1'b0;
        end
    end

    // Register the winning request onto the RAM port; address holds when idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= '0;
        end else if (w_vid_gnt) begin
            r_ram_addr <= vid_addr;
            r_ram_we   <= 1'b0;
        end else if (w_dl_gnt) begin
            r_ram_addr  <= r_dl_addr;
            r_ram_we    <= 1'b1;
            r_ram_wdata <= r_dl_data;
        end else if (w_cpu_gnt) begin
            r_ram_addr  <= cpu_addr;
            r_ram_we    <= cpu_we;
            r_ram_wdata <= cpu_wdata;
        end else begin
            r_ram_we <= 1'b0;
        end
    end

    // Video valid shift register: request at T -> strobe at T+2
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_vld_pipe <= '0;
        else          r_vld_pipe <= {r_vld_pipe[0], vid_req};
    end

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] r_stat_vid, r_stat_cpu, r_stat_dl;
    logic [7:0]  r_stat_max;

    assign stat_vid_cnt  = r_stat_vid;
    assign stat_cpu_cnt  = r_stat_cpu;
    assign stat_dl_cnt   = r_stat_dl;
    assign stat_max_wait = r_stat_max;

    // Saturating per-requester grant counters and peak CPU wait
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_vid <= '0;
            r_stat_cpu <= '0;
            r_stat_dl  <= '0;
            r_stat_max <= '0;
        end else begin
            if (w_vid_gnt && r_stat_vid != 16'hFFFF) r_stat_vid <= r_stat_vid + 16'd1;
            if (w_cpu_gnt && r_stat_cpu != 16'hFFFF) r_stat_cpu <= r_stat_cpu + 16'd1;
            if (w_dl_gnt  && r_stat_dl  != 16'hFFFF) r_stat_dl  <= r_stat_dl  + 16'd1;
            if (w_wait_nxt > r_stat_max) r_stat_max <= w_wait_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: stimulus pushes expected video/CPU
// responses (with their due cycle) into queues, a negedge monitor pops and
// compares. A behavioural synchronous RAM sits on the ram_* port.
module tb_vram_arbiter;
    localparam int AW = 11;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic [DW-1:0] vid_data;
    logic          vid_valid;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          dl_active = 1'b0;
    logic          dl_wr = 1'b0;
    logic [AW-1:0] dl_addr = '0;
    logic [DW-1:0] dl_data = '0;
    logic          dl_busy;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic          cpu_starve;
`ifdef VRAM_ARB_STATS_EN
    logic [15:0]   stat_vid_cnt, stat_cpu_cnt, stat_dl_cnt;
    logic [7:0]    stat_max_wait;
`endif

    vram_arbiter #(.AW(AW), .DW(DW), .STARVE_LIM(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
        .dl_busy(dl_busy),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
`ifdef VRAM_ARB_STATS_EN
        .stat_vid_cnt(stat_vid_cnt), .stat_cpu_cnt(stat_cpu_cnt),
        .stat_dl_cnt(stat_dl_cnt), .stat_max_wait(stat_max_wait),
`endif
        .cpu_starve(cpu_starve)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Initial RAM contents: a fixed pattern, with 0x123 holding 0x5A.
    function automatic logic [7:0] f(input logic [AW-1:0] a);
        if (a == 11'h123) return 8'h5A;
        return a[7:0] ^ {a[10:8], 5'h0B};
    endfunction

    logic [7:0]    mem [0:2047];
    logic [2047:0] wv = '0;

    function automatic logic [7:0] mem_rd(input logic [AW-1:0] a);
        return wv[a] ? mem[a] : f(a);
    endfunction

    // Synchronous read-first RAM, one-cycle read latency
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            wv[ram_addr]  <= 1'b1;
        end
        ram_rdata <= wv[ram_addr] ? mem[ram_addr] : f(ram_addr);
    end

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    typedef struct {
        int         cyc;
        logic [7:0] d;
    } exp_t;

    exp_t vq[$];
    exp_t cq[$];

    logic [39:0] all_outs;
    assign all_outs = {vid_data, vid_valid, cpu_rdata, cpu_ack, dl_busy,
                       ram_addr, ram_we, ram_wdata, cpu_starve};

    // Monitor: every video strobe / CPU ack must match the head of its queue
    always @(negedge clk) begin
        exp_t e;
        if (vid_valid) begin
            if (vq.size() == 0) check("vid_unexpected", 64'd1, 64'd0);
            else begin
                e = vq.pop_front();
                check("vid_cycle", 64'(cyc), 64'(e.cyc));
                check("vid_data", 64'(vid_data), 64'(e.d));
            end
        end
        if (cpu_ack) begin
            if (cq.size() == 0) check("cpu_ack_unexpected", 64'd1, 64'd0);
            else begin
                e = cq.pop_front();
                check("cpu_ack_cycle", 64'(cyc), 64'(e.cyc));
                check("cpu_rdata", 64'(cpu_rdata), 64'(e.d));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_vid(input logic [AW-1:0] a);
        vid_req  = 1'b1;
        vid_addr = a;
        vq.push_back(exp_t'{cyc + 2, f(a)});
    endtask

    task automatic cpu_rd(input logic [AW-1:0] a);
        tick();
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = a;
        cq.push_back(exp_t'{cyc + 3, mem_rd(a)});
        repeat (4) tick();
        cpu_req = 1'b0;
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        int a;
        int n;
        int errs;

        // Reset state
        repeat (3) tick();
        check("reset_outs", 64'(all_outs), 64'd0);
        reset_n = 1'b1;
        tick();

        // Idle CPU read of 0x123, req held long to prove a single ack
        tick();
        c = cyc;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h123;
        cq.push_back(exp_t'{c + 3, 8'h5A});
        tick();
        check("t2_ram_addr", 64'(ram_addr), 64'h123);
        check("t2_ram_we", 64'(ram_we), 64'd0);
        repeat (6) tick();
        cpu_req = 1'b0;
        tick();

        // 100 cycles of video with a stalled CPU write
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i == 0) begin
                cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h010; cpu_wdata = 8'h3C;
            end
            push_vid(11'h400 + 11'(i));
            if (i == 63) check("t3_starve_before", 64'(cpu_starve), 64'd0);
            if (i == 64) check("t3_starve_at_lim", 64'(cpu_starve), 64'd1);
        end
        tick();
        vid_req = 1'b0;
        cq.push_back(exp_t'{cyc + 3, 8'h5A});   // write: rdata unchanged
        repeat (4) tick();
        cpu_req = 1'b0; cpu_we = 1'b0;
        repeat (2) tick();
        check("t3_mem_010", 64'(mem_rd(11'h010)), 64'h3C);
        check("t3_starve_sticky", 64'(cpu_starve), 64'd1);

        // Download burst with alternating video and a pending CPU read
        tick();
        dl_active = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h200;
        a = 0;
        for (int k = 0; k < 2000 && a < 256; k++) begin
            if ((k % 2) == 1) push_vid(11'h400 + 11'(k & 255));
            else vid_req = 1'b0;
            if (!dl_busy) begin
                dl_wr = 1'b1; dl_addr = 11'(a); dl_data = 8'(a);
                a++;
            end else dl_wr = 1'b0;
            tick();
        end
        dl_wr = 1'b0; vid_req = 1'b0;
        n = 0;
        while (dl_busy && n < 10) begin
            tick();
            n++;
        end
        check("t4_drain", 64'(dl_busy), 64'd0);
        check("t4_count", 64'(a), 64'd256);
        dl_active = 1'b0;
        cq.push_back(exp_t'{cyc + 3, f(11'h200)});
        repeat (4) tick();
        cpu_req = 1'b0;
        repeat (2) tick();
        errs = 0;
        for (int i = 0; i < 256; i++)
            if (mem_rd(11'(i)) !== 8'(i)) errs++;
        check("t4_mem_bad", 64'(errs), 64'd0);

        // Collision: dl_wr with vid_req; second dl_wr while busy is dropped
        tick();
        dl_active = 1'b1;
        dl_wr = 1'b1; dl_addr = 11'h300; dl_data = 8'h77;
        push_vid(11'h450);
        check("t5_busy0", 64'(dl_busy), 64'd0);
        tick();
        dl_wr = 1'b1; dl_addr = 11'h301; dl_data = 8'hEE;
        push_vid(11'h451);
        check("t5_busy1", 64'(dl_busy), 64'd1);
        check("t5_addr1", 64'({ram_we, ram_addr}), 64'h450);
        tick();
        vid_req = 1'b0; dl_wr = 1'b0;
        check("t5_busy2", 64'(dl_busy), 64'd1);
        check("t5_addr2", 64'({ram_we, ram_addr}), 64'h451);
        tick();
        check("t5_busy3", 64'(dl_busy), 64'd0);
        check("t5_dl_issue", 64'({ram_we, ram_addr, ram_wdata}), {44'd0, 1'b1, 11'h300, 8'h77});
        dl_active = 1'b0;
        tick();
        check("t5_idle", 64'({ram_we, ram_addr}), 64'h300);
        repeat (2) tick();
        check("t5_mem_300", 64'(mem_rd(11'h300)), 64'h77);
        check("t5_mem_301", 64'(mem_rd(11'h301)), 64'(f(11'h301)));

        // Reset while the CPU access is in C_ISSUED
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h124;
        tick();
        reset_n = 1'b0;
        #1;
        check("t6_rst_outs", 64'(all_outs), 64'd0);
        tick();
        reset_n = 1'b1;
        cq.push_back(exp_t'{cyc + 3, f(11'h124)});
        repeat (5) tick();
        cpu_req = 1'b0;
        repeat (2) tick();
        check("t6_starve", 64'(cpu_starve), 64'd0);

`ifdef VRAM_ARB_STATS_EN
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0) begin
                cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h4F0;
                c = cyc;
            end
            push_vid(11'h400 + 11'(i));
        end
        tick();
        vid_req = 1'b0;
        n = cyc - c;   // cycles the first CPU access stalled
        cq.push_back(exp_t'{cyc + 3, f(11'h4F0)});
        repeat (4) tick();
        cpu_req = 1'b0;
        tick();
        for (int j = 0; j < 9; j++) cpu_rd(11'h4E0 + 11'(j));
        for (int j = 0; j < 5; j++) begin
            tick();
            dl_active = 1'b1; dl_wr = 1'b1; dl_addr = 11'h7F0 + 11'(j); dl_data = 8'(j);
            tick();
            dl_wr = 1'b0;
            tick();
        end
        dl_active = 1'b0;
        repeat (3) tick();
        check("st_vid", 64'(stat_vid_cnt), 64'd20);
        check("st_cpu", 64'(stat_cpu_cnt), 64'd10);
        check("st_dl", 64'(stat_dl_cnt), 64'd5);
        check("st_max_wait", 64'(stat_max_wait), 64'(n));
`endif

        repeat (4) tick();
        check("vid_queue_empty", 64'(vq.size()), 64'd0);
        check("cpu_queue_empty", 64'(cq.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
